thirty_two_bit_serial_alu: RTL and testbench

Multi-cycle 32-bit ALU that processes operands one 4-bit nibble per clock, least significant nibble first, over eight cycles. It serialises the same 4-bit-slice datapath that the parallel 32-bit logic units instantiate eight times. A ripple carry is held in a flip-flop between nibbles, so one nibble slice of area can replace eight. It sits behind a start/busy/done handshake driven by the datapath controller.

---
 rtl/thirty_two_bit_serial_alu_if.sv | 22 ++
 rtl/thirty_two_bit_serial_alu.sv | 156 +++++++++++++++
 tb/tb_thirty_two_bit_serial_alu.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/thirty_two_bit_serial_alu_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial ALU.
interface thirty_two_bit_serial_alu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/thirty_two_bit_serial_alu.sv
// 32-bit ALU computing one 4-bit slice per clock, LSB nibble first,
// with the ripple carry held in a flip-flop between slices.
module thirty_two_bit_serial_alu (
  input logic                        clk,
  input logic                        rst_n,
  thirty_two_bit_serial_alu_if.slave bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned OW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OW-1:0] OP_AND = 3'b000;
  localparam logic [OW-1:0] OP_OR  = 3'b001;
  localparam logic [OW-1:0] OP_XOR = 3'b010;
  localparam logic [OW-1:0] OP_NOT = 3'b011;
  localparam logic [OW-1:0] OP_ADD = 3'b100;
  localparam logic [OW-1:0] OP_SUB = 3'b101;
  localparam logic [OW-1:0] OP_NEG = 3'b110;

  logic [1:0]    r_state, w_nxt_state;
  logic [OW-1:0] r_op, w_nxt_op;
  logic [W-1:0]  r_a, w_nxt_a;
  logic [W-1:0]  r_b, w_nxt_b;
  logic [W-1:0]  r_result, w_nxt_result;
  logic [IW-1:0] r_idx, w_nxt_idx;
  logic          r_c, w_nxt_c;
  logic          r_busy, w_nxt_busy;
  logic          r_done, w_nxt_done;
  logic          r_carry_out, w_nxt_carry_out;
  logic          r_zero, w_nxt_zero;

  logic [NW-1:0] w_a_nib, w_b_nib, w_nib;
  logic [NW:0]   w_sum;
  logic          w_arith;

  // Single shared slice: selects the current nibble and evaluates the op on it.
  always_comb begin
    w_a_nib = r_a[{r_idx, 2'b00} +: NW];
    w_b_nib = r_b[{r_idx, 2'b00} +: NW];
    w_sum   = '0;
    w_nib   = '0;
    w_arith = 1'b0;
    case (r_op)
      OP_AND: w_nib = w_a_nib & w_b_nib;
      OP_OR:  w_nib = w_a_nib | w_b_nib;
      OP_XOR: w_nib = w_a_nib ^ w_b_nib;
      OP_NOT: w_nib = ~w_a_nib;
      OP_ADD: begin
        w_arith = 1'b1;
        w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + 5'(r_c);
        w_nib   = w_sum[NW-1:0];
      end
      OP_SUB: begin
        w_arith = 1'b1;
        w_sum   = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + 5'(r_c);
        w_nib   = w_sum[NW-1:0];
      end
      OP_NEG: begin
        w_arith = 1'b1;
        w_sum   = {1'b0, ~w_a_nib} + 5'(r_c);
        w_nib   = w_sum[NW-1:0];
      end
      default: w_nib = '0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_op        = r_op;
    w_nxt_a         = r_a;
    w_nxt_b         = r_b;
    w_nxt_result    = r_result;
    w_nxt_idx       = r_idx;
    w_nxt_c         = r_c;
    w_nxt_busy      = r_busy;
    w_nxt_done      = 1'b0;
    w_nxt_carry_out = r_carry_out;
    w_nxt_zero      = r_zero;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_nxt_state  = S_RUN;
          w_nxt_op     = bus.op;
          w_nxt_a      = bus.a;
          w_nxt_b      = bus.b;
          w_nxt_result = '0;
          w_nxt_idx    = '0;
          w_nxt_c      = (bus.op == OP_SUB) || (bus.op == OP_NEG);
          w_nxt_busy   = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_busy  = 1'b0;
        end
      end
      S_RUN: begin
        w_nxt_result[{r_idx, 2'b00} +: NW] = w_nib;
        w_nxt_c   = w_arith ? w_sum[NW] : 1'b0;
        w_nxt_idx = r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          w_nxt_state     = S_DONE;
          w_nxt_busy      = 1'b0;
          w_nxt_done      = 1'b1;
          w_nxt_carry_out = w_arith ? w_sum[NW] : 1'b0;
          w_nxt_zero      = (w_nxt_result == '0);
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_c         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_op        <= w_nxt_op;
      r_a         <= w_nxt_a;
      r_b         <= w_nxt_b;
      r_result    <= w_nxt_result;
      r_idx       <= w_nxt_idx;
      r_c         <= w_nxt_c;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
      r_carry_out <= w_nxt_carry_out;
      r_zero      <= w_nxt_zero;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_thirty_two_bit_serial_alu.sv
// Directed bench for the nibble-serial ALU: hand-computed results, latency and handshake.
module tb_thirty_two_bit_serial_alu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   lat;
  int   bcnt;
  int   dcnt;

  thirty_two_bit_serial_alu_if bus ();

  thirty_two_bit_serial_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits from the negedge after the start edge until done, bounded.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
      if (bus.busy === 1'b1) bc++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int bc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(l, bc);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, lat, bcnt);
    chk("add_lat", 32'(lat), 32'd8);
    chk("add_busycnt", 32'(bcnt), 32'd8);
    chk("add_busy_at_done", 32'(bus.busy), 32'd0);
    chk("add_res", bus.result, 32'h0);
    chk("add_carry", 32'(bus.carry_out), 32'd1);
    chk("add_zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    chk("add_done_1cyc", 32'(bus.done), 32'd0);
    chk("add_res_hold", bus.result, 32'h0);

    do_op(3'b101, 32'd5, 32'd7, lat, bcnt);
    chk("sub57_res", bus.result, 32'hFFFF_FFFE);
    chk("sub57_carry", 32'(bus.carry_out), 32'd0);
    chk("sub57_zero", 32'(bus.zero), 32'd0);

    do_op(3'b101, 32'd7, 32'd5, lat, bcnt);
    chk("sub75_res", bus.result, 32'h0000_0002);
    chk("sub75_carry", 32'(bus.carry_out), 32'd1);

    do_op(3'b011, 32'h0F0F_1234, 32'hFFFF_FFFF, lat, bcnt);
    chk("not_res", bus.result, 32'hF0F0_EDCB);
    chk("not_carry", 32'(bus.carry_out), 32'd0);

    do_op(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, bcnt);
    chk("xor_res", bus.result, 32'h0);
    chk("xor_zero", 32'(bus.zero), 32'd1);

    do_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, bcnt);
    chk("and_res", bus.result, 32'h00F0_1234);
    do_op(3'b001, 32'h1234_0000, 32'h0000_5678, lat, bcnt);
    chk("or_res", bus.result, 32'h1234_5678);

    do_op(3'b110, 32'h0000_0001, 32'h1234_5678, lat, bcnt);
    chk("neg1_res", bus.result, 32'hFFFF_FFFF);
    chk("neg1_carry", 32'(bus.carry_out), 32'd0);
    do_op(3'b110, 32'h0, 32'hFFFF_FFFF, lat, bcnt);
    chk("neg0_res", bus.result, 32'h0);
    chk("neg0_carry", 32'(bus.carry_out), 32'd1);

    do_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("rsvd_res", bus.result, 32'h0);
    chk("rsvd_carry", 32'(bus.carry_out), 32'd0);
    chk("rsvd_zero", 32'(bus.zero), 32'd1);

    // start and operand changes during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk("ign_lat", 32'(lat + 2), 32'd8);
    chk("ign_res", bus.result, 32'h2345_6789);
    chk("ign_carry", 32'(bus.carry_out), 32'd0);

    // start held high through done: back-to-back operations
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h8000_0000;
    bus.b     = 32'h8000_0000;
    @(negedge clk);
    bus.op    = 3'b101;
    bus.a     = 32'h0000_0010;
    bus.b     = 32'h0000_0001;
    wait_done(lat, bcnt);
    chk("b2b1_lat", 32'(lat), 32'd8);
    chk("b2b1_res", bus.result, 32'h0);
    chk("b2b1_carry", 32'(bus.carry_out), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b2_busy", 32'(bus.busy), 32'd1);
    chk("b2b2_done", 32'(bus.done), 32'd0);
    wait_done(lat, bcnt);
    chk("b2b2_lat", 32'(lat), 32'd8);
    chk("b2b2_res", bus.result, 32'h0000_000F);
    chk("b2b2_carry", 32'(bus.carry_out), 32'd1);
    chk("b2b2_zero", 32'(bus.zero), 32'd0);

    // reset asserted mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_result", bus.result, 32'h0);
    chk("mrst_carry", 32'(bus.carry_out), 32'd0);
    chk("mrst_zero", 32'(bus.zero), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
    end
    chk("mrst_no_done", 32'(dcnt), 32'd0);

    do_op(3'b100, 32'h0000_0003, 32'h0000_0004, lat, bcnt);
    chk("post_lat", 32'(lat), 32'd8);
    chk("post_res", bus.result, 32'h0000_0007);
    chk("post_carry", 32'(bus.carry_out), 32'd0);
    chk("post_zero", 32'(bus.zero), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
